// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the unified memory port arbiter.
// Latency: none (wires only).
// Backpressure: req held until ack on both requester channels; memory side has none.
//
// Ports / signals:
//   fetch : if_req, if_addr -> if_ack, if_rdata
//   data  : d_req, d_we, d_addr, d_wdata -> d_ack, d_rdata
//   memory: mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
//   stall : pipeline hold request
//   modport slave  = arbiter view, modport master = pipeline/memory environment view
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between fetch (read) and MEM stage (load/store).
// Latency: store ack 2 cycles after the request is seen in IDLE, load/fetch ack 2+MEM_LAT.
// Backpressure: one transaction in flight; losers wait with req held, stall holds the pipeline.
//
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : mem_port_arbiter_if.slave (fetch channel, data channel, memory macro, stall)
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mem_port_arbiter_if.slave       bus
);

    localparam logic [1:0] LAT_M1     = 2'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_owner_d;      // 1 = data port owns the transaction, 0 = fetch
    logic               r_we;           // store in flight (never set for fetch)
    logic [1:0]         r_wait_cnt;
    logic [3:0]         r_starve_cnt;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_d_rdata;

    logic               w_grant;
    logic               w_grant_d;
    logic               w_wait_last;

    // ------------------------------------------------------------------
    // Next-state logic and arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_d   = 1'b0;
        w_wait_last = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    w_grant     = 1'b1;
                    // Data wins unless fetch has already lost STARVE_MAX times in a row.
                    w_grant_d   = bus.d_req && (!bus.if_req || (r_starve_cnt != STARVE_LIM));
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Stores have no read data to wait for.
                w_state_nxt = r_we ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == 2'd0) begin
                    w_wait_last = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Requests are deliberately not sampled here: the requester only
                // sees its ack now and updates req for the next IDLE cycle.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Transaction registers, starvation counter, read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner_d    <= 1'b0;
            r_we         <= 1'b0;
            r_wait_cnt   <= 2'd0;
            r_starve_cnt <= 4'd0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            if (w_grant) begin
                r_owner_d  <= w_grant_d;
                r_we       <= w_grant_d & bus.d_we;
                r_mem_addr <= w_grant_d ? bus.d_addr : bus.if_addr;
                if (w_grant_d) begin
                    r_mem_wdata <= bus.d_wdata;
                end

                // Count only data grants that made a waiting fetch lose.
                if (!w_grant_d) begin
                    r_starve_cnt <= 4'd0;
                end else if (bus.if_req) begin
                    if (r_starve_cnt != STARVE_LIM) begin
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                end else begin
                    r_starve_cnt <= 4'd0;
                end
            end

            if (r_state == S_ISSUE) begin
                r_wait_cnt <= LAT_M1;
            end else if ((r_state == S_WAIT) && !w_wait_last) begin
                r_wait_cnt <= r_wait_cnt - 2'd1;
            end

            if (w_wait_last) begin
                if (r_owner_d) begin
                    r_d_rdata <= bus.mem_rdata;
                end else begin
                    r_if_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from the state register, so reset drops them at once)
    // ------------------------------------------------------------------
    assign bus.mem_en    = (r_state == S_ISSUE);
    assign bus.mem_we    = (r_state == S_ISSUE) & r_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    assign bus.if_ack    = (r_state == S_DONE) & ~r_owner_d;
    assign bus.d_ack     = (r_state == S_DONE) &  r_owner_d;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;

    // Gated by reset_n so the pipeline is not held while the arbiter is in reset.
    assign bus.stall     = reset_n & ((bus.if_req & ~bus.if_ack) | (bus.d_req & ~bus.d_ack));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(b1)
    );
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(b3)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          due;
        bit          chk;
    } exp_t;
    exp_t sb[$];

    // Memory model for MEM_LAT=1: unwritten words read as 0x2002_0001 + addr.
    logic [31:0]  m1_dat [0:255];
    logic [255:0] m1_wr = '0;
    logic         p1_v  = 1'b0;
    logic [31:0]  p1_d;
    always @(posedge clk) begin
        if (b1.mem_en && b1.mem_we) begin
            m1_dat[b1.mem_addr[9:2]] <= b1.mem_wdata;
            m1_wr[b1.mem_addr[9:2]]  <= 1'b1;
        end
        p1_v <= b1.mem_en && !b1.mem_we;
        p1_d <= m1_wr[b1.mem_addr[9:2]] ? m1_dat[b1.mem_addr[9:2]] : 32'h2002_0001 + b1.mem_addr;
    end
    assign b1.mem_rdata = p1_v ? p1_d : 32'hBAD0_BAD0;

    // Memory model for MEM_LAT=3 (read-only): word = 0x1234_55F8 + addr.
    logic [2:0]  p3_v = 3'b000;
    logic [31:0] p3_d [0:2];
    always @(posedge clk) begin
        p3_v    <= {p3_v[1:0], b3.mem_en && !b3.mem_we};
        p3_d[0] <= 32'h1234_55F8 + b3.mem_addr;
        p3_d[1] <= p3_d[0];
        p3_d[2] <= p3_d[1];
    end
    assign b3.mem_rdata = p3_v[2] ? p3_d[2] : 32'hBAD0_BAD0;

    task automatic start_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        b1.if_req = 1'b1; b1.d_req = 1'b1; b3.if_req = 1'b1;
        #2 reset_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (b1.stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall1: got %0b want 0", b1.stall); end
        n_cmp++; if (b3.stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall3: got %0b want 0", b3.stall); end
        n_cmp++; if (b1.mem_en !== 1'b0) begin n_bad++; $display("FAIL reset_mem_en: got %0b want 0", b1.mem_en); end
        n_cmp++; if (b1.mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %0b want 0", b1.mem_we); end
        n_cmp++; if (b1.if_ack !== 1'b0) begin n_bad++; $display("FAIL reset_if_ack: got %0b want 0", b1.if_ack); end
        n_cmp++; if (b1.d_ack !== 1'b0) begin n_bad++; $display("FAIL reset_d_ack: got %0b want 0", b1.d_ack); end
        n_cmp++; if (b1.mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", b1.mem_addr); end
        n_cmp++; if (b1.if_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_if_rdata: got %h want 0", b1.if_rdata); end
        n_cmp++; if (b1.d_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_d_rdata: got %h want 0", b1.d_rdata); end
        b1.if_req = 1'b0; b1.d_req = 1'b0; b3.if_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (b1.mem_en !== 1'b0) begin n_bad++; $display("FAIL post_reset_mem_en: got %0b want 0", b1.mem_en); end
    endtask

    task automatic test_fetch();
        int   c0;
        int   c;
        bit   got;
        exp_t e;
        start_cycle();
        b1.if_req = 1'b1; b1.if_addr = 32'h0000_0004;
        c0 = cyc;
        sb.push_back('{1'b0, 32'h2002_0005, c0 + 3, 1'b1});
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            c = cyc - c0;
            n_cmp++; if (b1.mem_en !== (c == 1)) begin n_bad++; $display("FAIL fetch_mem_en c%0d: got %0b want %0b", c, b1.mem_en, (c == 1)); end
            n_cmp++; if (b1.stall !== (c < 3)) begin n_bad++; $display("FAIL fetch_stall c%0d: got %0b want %0b", c, b1.stall, (c < 3)); end
            n_cmp++; if (b1.d_ack !== 1'b0) begin n_bad++; $display("FAIL fetch_d_ack c%0d: got %0b want 0", c, b1.d_ack); end
            if (c == 1) begin
                n_cmp++; if (b1.mem_addr !== 32'h4) begin n_bad++; $display("FAIL fetch_mem_addr: got %h want 4", b1.mem_addr); end
            end
            if (b1.if_ack || b1.d_ack) begin
                got = 1'b1;
                if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL fetch_unexpected_ack: got ack want none"); end
                else begin
                    e = sb.pop_front();
                    n_cmp++; if (b1.d_ack !== e.is_d) begin n_bad++; $display("FAIL fetch_owner: got d=%0b want d=%0b", b1.d_ack, e.is_d); end
                    n_cmp++; if (cyc !== e.due) begin n_bad++; $display("FAIL fetch_latency: got cycle %0d want %0d", cyc - c0, e.due - c0); end
                    n_cmp++; if (b1.if_rdata !== e.data) begin n_bad++; $display("FAIL fetch_rdata: got %h want %h", b1.if_rdata, e.data); end
                end
            end
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL fetch_timeout: got no ack want ack"); end
        start_cycle();
        b1.if_req = 1'b0;
    endtask

    task automatic test_store();
        int   c0;
        int   c;
        bit   got;
        exp_t e;
        start_cycle();
        b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'h40; b1.d_wdata = 32'hDEAD_BEEF;
        c0 = cyc;
        sb.push_back('{1'b1, 32'h0, c0 + 2, 1'b0});
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            c = cyc - c0;
            n_cmp++; if (b1.mem_en !== (c == 1)) begin n_bad++; $display("FAIL store_mem_en c%0d: got %0b want %0b", c, b1.mem_en, (c == 1)); end
            n_cmp++; if (b1.mem_we !== (c == 1)) begin n_bad++; $display("FAIL store_mem_we c%0d: got %0b want %0b", c, b1.mem_we, (c == 1)); end
            n_cmp++; if (b1.if_ack !== 1'b0) begin n_bad++; $display("FAIL store_if_ack c%0d: got %0b want 0", c, b1.if_ack); end
            if (c == 1) begin
                n_cmp++; if (b1.mem_addr !== 32'h40) begin n_bad++; $display("FAIL store_mem_addr: got %h want 40", b1.mem_addr); end
                n_cmp++; if (b1.mem_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL store_mem_wdata: got %h want deadbeef", b1.mem_wdata); end
            end
            if (b1.if_ack || b1.d_ack) begin
                got = 1'b1;
                if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL store_unexpected_ack: got ack want none"); end
                else begin
                    e = sb.pop_front();
                    n_cmp++; if (b1.d_ack !== e.is_d) begin n_bad++; $display("FAIL store_owner: got d=%0b want d=%0b", b1.d_ack, e.is_d); end
                    n_cmp++; if (cyc !== e.due) begin n_bad++; $display("FAIL store_latency: got cycle %0d want %0d", cyc - c0, e.due - c0); end
                end
            end
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL store_timeout: got no ack want ack"); end
        start_cycle();
        b1.d_req = 1'b0; b1.d_we = 1'b0;
    endtask

    task automatic test_starve();
        int   c0;
        int   n_got;
        exp_t e;
        start_cycle();
        b1.if_req = 1'b1; b1.if_addr = 32'h4;
        b1.d_req  = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h40;
        c0 = cyc;
        // Loads and fetches each take 4 cycles with MEM_LAT=1; every fifth grant is forced to fetch.
        for (int i = 0; i < 10; i++) begin
            if ((i % 5) == 4) sb.push_back('{1'b0, 32'h2002_0005, c0 + 3 + 4 * i, 1'b1});
            else              sb.push_back('{1'b1, 32'hDEAD_BEEF, c0 + 3 + 4 * i, 1'b1});
        end
        n_got = 0;
        for (int k = 0; k < 80 && n_got < 10; k++) begin
            @(negedge clk);
            n_cmp++; if (b1.if_ack && b1.d_ack) begin n_bad++; $display("FAIL starve_dual_ack: got both acks want at most one"); end
            if (b1.if_ack || b1.d_ack) begin
                n_got++;
                if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL starve_unexpected_ack: got ack want none"); end
                else begin
                    e = sb.pop_front();
                    n_cmp++; if (b1.d_ack !== e.is_d) begin n_bad++; $display("FAIL starve_owner #%0d: got d=%0b want d=%0b", n_got, b1.d_ack, e.is_d); end
                    n_cmp++; if (cyc !== e.due) begin n_bad++; $display("FAIL starve_timing #%0d: got cycle %0d want %0d", n_got, cyc - c0, e.due - c0); end
                    n_cmp++; if ((b1.d_ack ? b1.d_rdata : b1.if_rdata) !== e.data) begin n_bad++; $display("FAIL starve_rdata #%0d: got %h want %h", n_got, (b1.d_ack ? b1.d_rdata : b1.if_rdata), e.data); end
                end
            end
        end
        n_cmp++; if (n_got != 10) begin n_bad++; $display("FAIL starve_timeout: got %0d acks want 10", n_got); end
        start_cycle();
        b1.if_req = 1'b0; b1.d_req = 1'b0;
        sb.delete();
    endtask

    task automatic test_ack_same_cycle();
        int   c0;
        exp_t e;
        int   n_got;
        start_cycle();
        b1.if_req = 1'b1; b1.if_addr = 32'h4;
        c0 = cyc;
        n_got = 0;
        sb.push_back('{1'b0, 32'h2002_0005, c0 + 3, 1'b1});
        for (int c = 0; c < 8; c++) begin
            if (c > 0) start_cycle();
            if (c == 3) begin
                b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'h44; b1.d_wdata = 32'h0BAD_F00D;
                sb.push_back('{1'b1, 32'h0, c0 + 6, 1'b0});
            end
            if (c == 4) b1.if_req = 1'b0;
            if (c == 7) b1.d_req = 1'b0;
            @(negedge clk);
            n_cmp++; if (b1.mem_en !== (c == 1 || c == 5)) begin n_bad++; $display("FAIL same_mem_en c%0d: got %0b want %0b", c, b1.mem_en, (c == 1 || c == 5)); end
            if (c == 3) begin
                n_cmp++; if (b1.stall !== 1'b1) begin n_bad++; $display("FAIL same_stall c3: got %0b want 1", b1.stall); end
            end
            if (b1.if_ack || b1.d_ack) begin
                n_got++;
                if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL same_unexpected_ack c%0d: got ack want none", c); end
                else begin
                    e = sb.pop_front();
                    n_cmp++; if (b1.d_ack !== e.is_d) begin n_bad++; $display("FAIL same_owner c%0d: got d=%0b want d=%0b", c, b1.d_ack, e.is_d); end
                    n_cmp++; if (cyc !== e.due) begin n_bad++; $display("FAIL same_timing: got cycle %0d want %0d", c, e.due - c0); end
                    if (e.chk) begin
                        n_cmp++; if (b1.if_rdata !== e.data) begin n_bad++; $display("FAIL same_rdata: got %h want %h", b1.if_rdata, e.data); end
                    end
                end
            end
        end
        n_cmp++; if (n_got != 2) begin n_bad++; $display("FAIL same_ack_count: got %0d want 2", n_got); end
        sb.delete();
    endtask

    task automatic test_lat3();
        int   c0;
        int   c;
        bit   got;
        exp_t e;
        start_cycle();
        b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 32'h80;
        c0 = cyc;
        sb.push_back('{1'b1, 32'h1234_5678, c0 + 5, 1'b1});
        got = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            @(negedge clk);
            c = cyc - c0;
            n_cmp++; if (b3.mem_en !== (c == 1)) begin n_bad++; $display("FAIL lat3_mem_en c%0d: got %0b want %0b", c, b3.mem_en, (c == 1)); end
            if (b3.if_ack || b3.d_ack) begin
                got = 1'b1;
                if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL lat3_unexpected_ack: got ack want none"); end
                else begin
                    e = sb.pop_front();
                    n_cmp++; if (b3.d_ack !== e.is_d) begin n_bad++; $display("FAIL lat3_owner: got d=%0b want d=%0b", b3.d_ack, e.is_d); end
                    n_cmp++; if (cyc !== e.due) begin n_bad++; $display("FAIL lat3_latency: got cycle %0d want %0d", c, e.due - c0); end
                    n_cmp++; if (b3.d_rdata !== e.data) begin n_bad++; $display("FAIL lat3_rdata: got %h want %h", b3.d_rdata, e.data); end
                end
            end
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL lat3_timeout: got no ack want ack"); end

        // Back-to-back fetch; load data must stay put.
        start_cycle();
        b3.d_req = 1'b0; b3.if_req = 1'b1; b3.if_addr = 32'h4;
        c0 = cyc;
        sb.push_back('{1'b0, 32'h1234_55FC, c0 + 5, 1'b1});
        got = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            @(negedge clk);
            n_cmp++; if (b3.d_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL lat3_d_rdata_hold: got %h want 12345678", b3.d_rdata); end
            if (b3.if_ack || b3.d_ack) begin
                got = 1'b1;
                if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL lat3f_unexpected_ack: got ack want none"); end
                else begin
                    e = sb.pop_front();
                    n_cmp++; if (b3.d_ack !== e.is_d) begin n_bad++; $display("FAIL lat3f_owner: got d=%0b want d=%0b", b3.d_ack, e.is_d); end
                    n_cmp++; if (cyc !== e.due) begin n_bad++; $display("FAIL lat3f_latency: got cycle %0d want %0d", cyc - c0, e.due - c0); end
                    n_cmp++; if (b3.if_rdata !== e.data) begin n_bad++; $display("FAIL lat3f_rdata: got %h want %h", b3.if_rdata, e.data); end
                end
            end
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL lat3f_timeout: got no ack want ack"); end
        start_cycle();
        b3.if_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int   c0;
        bit   got;
        exp_t e;
        start_cycle();
        b3.if_req = 1'b1; b3.if_addr = 32'h8;
        c0 = cyc;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) start_cycle();
            if (c == 2) begin
                b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'h48; b1.d_wdata = 32'h5555_AAAA;
            end
            @(negedge clk);
        end
        // dut3 is in WAIT, dut1 is in ISSUE of its store.
        n_cmp++; if (b1.mem_en !== 1'b1) begin n_bad++; $display("FAIL abort_pre_mem_en: got %0b want 1", b1.mem_en); end
        #1 reset_n = 1'b0;
        #1;
        n_cmp++; if (b1.mem_en !== 1'b0) begin n_bad++; $display("FAIL abort_mem_en1: got %0b want 0", b1.mem_en); end
        n_cmp++; if (b1.mem_we !== 1'b0) begin n_bad++; $display("FAIL abort_mem_we1: got %0b want 0", b1.mem_we); end
        n_cmp++; if (b3.mem_en !== 1'b0) begin n_bad++; $display("FAIL abort_mem_en3: got %0b want 0", b3.mem_en); end
        n_cmp++; if (b3.stall !== 1'b0) begin n_bad++; $display("FAIL abort_stall3: got %0b want 0", b3.stall); end
        n_cmp++; if (b3.if_rdata !== 32'h0) begin n_bad++; $display("FAIL abort_if_rdata3: got %h want 0", b3.if_rdata); end
        b3.if_req = 1'b0; b1.d_req = 1'b0; b1.d_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if ((b3.if_ack | b3.d_ack | b1.if_ack | b1.d_ack) !== 1'b0) begin n_bad++; $display("FAIL abort_ack k%0d: got ack want none", k); end
            n_cmp++; if (b3.mem_en !== 1'b0) begin n_bad++; $display("FAIL abort_hold_mem_en k%0d: got %0b want 0", k, b3.mem_en); end
        end
        start_cycle();
        reset_n = 1'b1;
        start_cycle();
        b3.if_req = 1'b1; b3.if_addr = 32'h8;
        c0 = cyc;
        sb.push_back('{1'b0, 32'h1234_5600, c0 + 5, 1'b1});
        got = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            @(negedge clk);
            if (b3.if_ack || b3.d_ack) begin
                got = 1'b1;
                if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL recover_unexpected_ack: got ack want none"); end
                else begin
                    e = sb.pop_front();
                    n_cmp++; if (b3.d_ack !== e.is_d) begin n_bad++; $display("FAIL recover_owner: got d=%0b want d=%0b", b3.d_ack, e.is_d); end
                    n_cmp++; if (cyc !== e.due) begin n_bad++; $display("FAIL recover_latency: got cycle %0d want %0d", cyc - c0, e.due - c0); end
                    n_cmp++; if (b3.if_rdata !== e.data) begin n_bad++; $display("FAIL recover_rdata: got %h want %h", b3.if_rdata, e.data); end
                end
            end
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL recover_timeout: got no ack want ack"); end
        start_cycle();
        b3.if_req = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b1;
        b1.if_req  = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
        b3.if_req  = 1'b0; b3.if_addr = '0; b3.d_req = 1'b0; b3.d_we = 1'b0; b3.d_addr = '0; b3.d_wdata = '0;
        test_reset();
        test_fetch();
        test_store();
        test_starve();
        test_ack_same_cycle();
        test_lat3();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
